// File: rtl/aux_row_reader_pkg.sv
// Shared definitions for the aux row reader: FSM state encoding, character
// constants and the nibble-to-ASCII conversion.
// Build option: AUX_ROW_READER_ZERO_BLANK_EN blanks leading zero nibbles.
package aux_row_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        EMIT,
        SEP,
        DONE
    } state_e;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam int         CHARS_PER_ROW = 14;

`ifdef AUX_ROW_READER_ZERO_BLANK_EN
    localparam bit ZERO_BLANK_EN = 1'b1;
`else
    localparam bit ZERO_BLANK_EN = 1'b0;
`endif

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/hex_word_serializer.sv
// Serialises one aux word into four hex characters, MSB nibble first, with a
// valid/ready handshake. Reused by the row reader for every word of a row.
// With AUX_ROW_READER_ZERO_BLANK_EN defined, leading zero nibbles are sent as
// spaces while the final nibble is always a digit.
module hex_word_serializer
    import aux_row_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  clear_in,
    input  logic                  load_in,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  ready_in,
    output logic [7:0]            char_out,
    output logic                  valid_out,
    output logic                  last_xfer_out
);

    logic [DATA_WIDTH-1:0] word_q;
    logic [1:0]            cnt_q;
    logic                  lead_q;
    logic                  valid_q;
    logic [7:0]            char_q;
    logic [3:0]            load_nib;
    logic [3:0]            next_nib;
    logic                  xfer;

    // word_q is kept pre-shifted so its top nibble is always the next one to send
    assign load_nib = word_in[DATA_WIDTH-1 -: 4];
    assign next_nib = word_q[DATA_WIDTH-1 -: 4];
    assign xfer     = valid_q && ready_in;

    assign char_out      = char_q;
    assign valid_out     = valid_q;
    assign last_xfer_out = xfer && (cnt_q == 2'd3);

    // Character for a nibble, blanking it when still inside a leading-zero run
    function automatic logic [7:0] nib_char(input logic [3:0] nib,
                                            input logic       still_lead,
                                            input logic       is_last);
        if (ZERO_BLANK_EN && still_lead && (nib == 4'h0) && !is_last) begin
            return ASCII_SPACE;
        end
        return nibble_to_ascii(nib);
    endfunction

    // Load a word, then advance one nibble per accepted character
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            word_q  <= '0;
            cnt_q   <= 2'd0;
            lead_q  <= 1'b0;
            valid_q <= 1'b0;
            char_q  <= 8'h00;
        end else if (clear_in) begin
            valid_q <= 1'b0;
        end else if (load_in) begin
            word_q  <= word_in << 4;
            cnt_q   <= 2'd0;
            lead_q  <= (load_nib == 4'h0);
            valid_q <= 1'b1;
            char_q  <= nib_char(load_nib, 1'b1, 1'b0);
        end else if (xfer) begin
            if (cnt_q == 2'd3) begin
                valid_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + 2'd1;
                word_q <= word_q << 4;
                lead_q <= lead_q && (next_nib == 4'h0);
                char_q <= nib_char(next_nib, lead_q, (cnt_q == 2'd2));
            end
        end
    end

endmodule

// File: rtl/aux_row_reader.sv
// Reads the three aux words of one row (CPU, instruction, data) and streams
// them as "HHHH HHHH HHHH" ASCII characters to a renderer.
// Build option: AUX_ROW_READER_ZERO_BLANK_EN (leading-zero blanking).
module aux_row_reader
    import aux_row_reader_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5,
    parameter int CPU_ELEMENTS      = 10,
    parameter int MEMORY_ELEMENTS   = 10
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         v_sync_in,
    input  logic                         row_request_in,
    input  logic [3:0]                   row_index_in,
    input  logic [DATA_WIDTH-1:0]        aux_data_in,
    output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
    output logic [7:0]                   char_code_out,
    output logic                         char_valid_out,
    input  logic                         char_ready_in,
    output logic                         busy_out,
    output logic                         row_done_out,
    output logic                         row_abort_out
);

    state_e                         state_q;
    logic [3:0]                     row_q;
    logic [1:0]                     word_sel_q;
    logic [3:0]                     xfer_cnt_q;
    logic [AUX_ADDRESS_WIDTH-1:0]   raddr_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           abort_q;
    logic                           sep_valid_q;

    logic [7:0] ser_char;
    logic       ser_valid;
    logic       ser_last_xfer;
    logic       ser_load;
    logic       abort;
    logic       xfer;
    logic       req_ok;

    // Address of word 'sel' (0 CPU, 1 instruction, 2 data) for a given row
    function automatic logic [AUX_ADDRESS_WIDTH-1:0] word_addr(input logic [1:0] sel,
                                                             input logic [3:0] row);
        logic [AUX_ADDRESS_WIDTH-1:0] base;
        case (sel)
            2'd0:    base = '0;
            2'd1:    base = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS);
            default: base = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS + MEMORY_ELEMENTS);
        endcase
        return base + AUX_ADDRESS_WIDTH'(row);
    endfunction

    // The aux writer may run while v_sync is low, so a busy row is abandoned then
    assign abort    = busy_q && !v_sync_in;
    assign xfer     = char_valid_out && char_ready_in;
    assign req_ok   = row_request_in && v_sync_in && (int'(row_index_in) < CPU_ELEMENTS);
    assign ser_load = (state_q == CAPTURE);

    assign aux_raddress_out = raddr_q;
    assign busy_out         = busy_q;
    assign row_done_out     = done_q;
    assign row_abort_out    = abort_q;
    assign char_valid_out   = ser_valid || sep_valid_q;
    assign char_code_out    = sep_valid_q ? ASCII_SPACE : ser_char;

    hex_word_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clock_in     (clock_in),
        .reset_n_in   (reset_n_in),
        .clear_in     (abort),
        .load_in      (ser_load),
        .word_in      (aux_data_in),
        .ready_in     (char_ready_in),
        .char_out     (ser_char),
        .valid_out    (ser_valid),
        .last_xfer_out(ser_last_xfer)
    );

    // Row sequencing: fetch/capture each word, emit its nibbles, then a separator
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= IDLE;
            row_q       <= 4'd0;
            word_sel_q  <= 2'd0;
            xfer_cnt_q  <= 4'd0;
            raddr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            sep_valid_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                sep_valid_q <= 1'b0;
                abort_q     <= 1'b1;
            end else begin
                if (xfer) begin
                    xfer_cnt_q <= xfer_cnt_q + 4'd1;
                end
                case (state_q)
                    IDLE: begin
                        if (req_ok) begin
                            row_q      <= row_index_in;
                            word_sel_q <= 2'd0;
                            xfer_cnt_q <= 4'd0;
                            raddr_q    <= word_addr(2'd0, row_index_in);
                            busy_q     <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                    FETCH:   state_q <= CAPTURE;
                    CAPTURE: state_q <= EMIT;
                    EMIT: begin
                        if (ser_last_xfer) begin
                            if (xfer_cnt_q == 4'(CHARS_PER_ROW - 1)) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= SEP;
                                sep_valid_q <= 1'b1;
                            end
                        end
                    end
                    SEP: begin
                        if (char_ready_in) begin
                            sep_valid_q <= 1'b0;
                            word_sel_q  <= word_sel_q + 2'd1;
                            raddr_q     <= word_addr(word_sel_q + 2'd1, row_q);
                            state_q     <= FETCH;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aux_row_reader.sv
// Randomised scoreboard bench for aux_row_reader. Expected characters come
// from a text-formatting model of each row; a monitor pops them on transfers.
module tb_aux_row_reader;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int CPU = 10;
    localparam int MEM = 10;

    logic          clock_in       = 1'b0;
    logic          reset_n_in     = 1'b0;
    logic          v_sync_in      = 1'b1;
    logic          row_request_in = 1'b0;
    logic [3:0]    row_index_in   = 4'd0;
    logic [DW-1:0] aux_data_in    = '0;
    logic          char_ready_in  = 1'b1;
    logic [AW-1:0] aux_raddress_out;
    logic [7:0]    char_code_out;
    logic          char_valid_out;
    logic          busy_out;
    logic          row_done_out;
    logic          row_abort_out;

    logic [DW-1:0] mem [32];
    logic [7:0]    exp_q [$];

    int checks       = 0;
    int errors       = 0;
    int xfers        = 0;
    int done_pulses  = 0;
    int abort_pulses = 0;
    int ready_mode   = 0;

    aux_row_reader #(
        .DATA_WIDTH       (DW),
        .AUX_ADDRESS_WIDTH(AW),
        .CPU_ELEMENTS     (CPU),
        .MEMORY_ELEMENTS  (MEM)
    ) dut (
        .clock_in        (clock_in),
        .reset_n_in      (reset_n_in),
        .v_sync_in       (v_sync_in),
        .row_request_in  (row_request_in),
        .row_index_in    (row_index_in),
        .aux_data_in     (aux_data_in),
        .aux_raddress_out(aux_raddress_out),
        .char_code_out   (char_code_out),
        .char_valid_out  (char_valid_out),
        .char_ready_in   (char_ready_in),
        .busy_out        (busy_out),
        .row_done_out    (row_done_out),
        .row_abort_out   (row_abort_out)
    );

    always #5 clock_in = ~clock_in;

    // Aux buffer with one cycle of read latency
    always @(posedge clock_in) aux_data_in <= mem[aux_raddress_out];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: format three words as hex text separated by single spaces
    function automatic void push_row(input logic [15:0] w0, input logic [15:0] w1,
                                     input logic [15:0] w2);
        logic [15:0] w [3];
        bit          blank_en;
        bit          lead;
        int          nib;
        logic [7:0]  c;
`ifdef AUX_ROW_READER_ZERO_BLANK_EN
        blank_en = 1'b1;
`else
        blank_en = 1'b0;
`endif
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int k = 0; k < 3; k++) begin
            lead = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                nib = int'((w[k] >> (4 * i)) & 16'hF);
                c = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
                if (blank_en && lead && nib == 0 && i != 0) c = 8'h20;
                if (nib != 0) lead = 1'b0;
                exp_q.push_back(c);
            end
            if (k < 2) exp_q.push_back(8'h20);
        end
    endfunction

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    // Pulse a request for one edge; the model decides whether it should be taken
    task automatic request(input int row, input bit idle);
        bit acc;
        acc = idle && v_sync_in && (row < CPU);
        row_request_in = 1'b1;
        row_index_in   = 4'(row);
        if (acc) push_row(mem[row], mem[CPU + row], mem[CPU + MEM + row]);
        step();
        row_request_in = 1'b0;
    endtask

    task automatic wait_row_end(input string name, input int budget);
        int n;
        n = 0;
        while (!row_done_out && n < budget) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, 32'(row_done_out), 32'd1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n;
        n = 0;
        while (xfers < target && n < budget) begin
            step();
            n++;
        end
        check("xfer_target_reached", 32'(xfers >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_raddr"}, 32'(aux_raddress_out), 32'd0);
        check({tag, "_char"},  32'(char_code_out),    32'd0);
        check({tag, "_valid"}, 32'(char_valid_out),   32'd0);
        check({tag, "_busy"},  32'(busy_out),         32'd0);
        check({tag, "_done"},  32'(row_done_out),     32'd0);
        check({tag, "_abort"}, 32'(row_abort_out),    32'd0);
    endtask

    // Ready generator: always high, 1-0-0-1 pattern, random, or left to main
    initial begin : ready_gen
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clock_in);
            #1;
            cyc++;
            case (ready_mode)
                0: char_ready_in = 1'b1;
                1: char_ready_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: char_ready_in = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_code;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_code  = 8'h00;
        forever begin
            @(negedge clock_in);
            if (!reset_n_in) begin
                prev_stall = 1'b0;
                continue;
            end
            if (row_done_out)  done_pulses++;
            if (row_abort_out) abort_pulses++;
            if (prev_stall && char_valid_out) check("stall_hold", 32'(char_code_out), 32'(prev_code));
            if (char_valid_out && char_ready_in) begin
                xfers++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_char: got 0x%0h, expected no character", char_code_out);
                end else begin
                    e = exp_q.pop_front();
                    if (char_code_out !== e) begin
                        errors++;
                        $display("FAIL char: got 0x%0h, expected 0x%0h", char_code_out, e);
                    end
                end
            end
            prev_stall = char_valid_out && !char_ready_in;
            prev_code  = char_code_out;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base_d, base_a, base_x, row;
        logic [AW-1:0] r0;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[3]  = 16'h1234; mem[13] = 16'hABCD; mem[23] = 16'h00F0;
        mem[0]  = 16'h0000; mem[10] = 16'h00F0; mem[20] = 16'h0A05;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        reset_n_in = 1'b1;

        // Basic row 3, request on the first edge after reset release
        base_d = done_pulses;
        request(3, 1'b1);
        check("basic_busy_k", 32'(busy_out), 32'd1);
        check("basic_raddr_k", 32'(aux_raddress_out), 32'd3);
        check("basic_valid_k", 32'(char_valid_out), 32'd0);
        step();
        check("basic_valid_k1", 32'(char_valid_out), 32'd0);
        step();
        check("basic_valid_k2", 32'(char_valid_out), 32'd1);
        check("basic_first_char", 32'(char_code_out), 32'h31);
        wait_row_end("basic", 200);
        check("basic_busy_in_done", 32'(busy_out), 32'd0);
        step(); step();
        check("basic_done_once", 32'(done_pulses - base_d), 32'd1);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("row 3 basic complete");

        // Backpressure with ready 1-0-0-1
        ready_mode = 1;
        request(5, 1'b1);
        wait_row_end("bp", 400);
        step();
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("row 5 backpressure complete");
        ready_mode = 0;

        // Invalid row, v_sync low, then requests while busy and in DONE
        step();
        r0 = aux_raddress_out;
        request(10, 1'b1);
        repeat (3) step();
        check("inv_busy", 32'(busy_out), 32'd0);
        check("inv_raddr", 32'(aux_raddress_out), 32'(r0));
        v_sync_in = 1'b0;
        request(4, 1'b1);
        v_sync_in = 1'b1;
        repeat (2) step();
        check("vs_busy", 32'(busy_out), 32'd0);
        check("vs_raddr", 32'(aux_raddress_out), 32'(r0));
        base_d = done_pulses;
        request(6, 1'b1);
        step(); step();
        request(2, 1'b0);
        wait_row_end("busyreq", 200);
        request(8, 1'b0);
        step(); step();
        check("donereq_busy", 32'(busy_out), 32'd0);
        check("busyreq_done_once", 32'(done_pulses - base_d), 32'd1);
        check("busyreq_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("row 6 with ignored requests complete");

        // Abort after the sixth character
        ready_mode = 3;
        char_ready_in = 1'b1;
        base_x = xfers; base_a = abort_pulses; base_d = done_pulses;
        request(7, 1'b1);
        wait_xfers(base_x + 6, 200);
        v_sync_in = 1'b0;
        char_ready_in = 1'b0;
        step();
        check("abort_valid", 32'(char_valid_out), 32'd0);
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_pulse", 32'(row_abort_out), 32'd1);
        step();
        check("abort_pulse_end", 32'(row_abort_out), 32'd0);
        check("abort_once", 32'(abort_pulses - base_a), 32'd1);
        check("abort_no_done", 32'(done_pulses - base_d), 32'd0);
        check("abort_remaining", 32'(exp_q.size()), 32'd8);
        exp_q.delete();
        v_sync_in = 1'b1;
        ready_mode = 0;
        step();
        $display("row 7 aborted");

        // Asynchronous reset in the middle of a word, then row 0
        base_x = xfers;
        request(2, 1'b1);
        wait_xfers(base_x + 2, 200);
        #2;
        reset_n_in = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        step();
        reset_n_in = 1'b1;
        request(0, 1'b1);
        check("post_reset_busy", 32'(busy_out), 32'd1);
        wait_row_end("row0", 200);
        step();
        check("row0_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("row 0 after reset complete");

        // Random rows, words and ready behaviour
        for (int t = 0; t < 12; t++) begin
            ready_mode = int'($urandom_range(0, 2));
            row = int'($urandom_range(0, 11));
            for (int k = 0; k < 3; k++) begin
                if (row < CPU) mem[row + k * CPU] = 16'($urandom) & 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            end
            request(row, 1'b1);
            if (row < CPU) begin
                wait_row_end("rand", 1000);
                step();
                check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
            end else begin
                repeat (3) step();
                check("rand_invalid_busy", 32'(busy_out), 32'd0);
            end
            $display("random row %0d (ready mode %0d) done", row, ready_mode);
        end

        ready_mode = 0;
        repeat (3) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aux_row_reader.md
AUX_ROW_READER -- requirements
Module: aux_row_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning aux buffer word width.
REQ-002 SHALL have parameter AUX_ADDRESS_WIDTH, default 5, meaning aux buffer address width.
REQ-003 SHALL have parameter CPU_ELEMENTS, default 10, meaning rows and count of CPU words at aux base 0.
REQ-004 SHALL have parameter MEMORY_ELEMENTS, default 10, meaning count of instruction words at base CPU_ELEMENTS and of data words at base CPU_ELEMENTS+MEMORY_ELEMENTS.
REQ-005 SHALL have port clock_in, input, 1, meaning single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n_in, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port v_sync_in, input, 1, meaning frame sync; low means the aux writer may be active.
REQ-008 SHALL have port row_request_in, input, 1, meaning single-cycle request to render one row.
REQ-009 SHALL have port row_index_in, input, 4, meaning requested row, sampled with row_request_in.
REQ-010 SHALL have port aux_data_in, input, DATA_WIDTH, meaning aux buffer read data, valid one cycle after address.
REQ-011 SHALL have port aux_raddress_out, output, AUX_ADDRESS_WIDTH, meaning aux buffer read address.
REQ-012 SHALL have port char_code_out, output, 8, meaning ASCII character.
REQ-013 SHALL have port char_valid_out, output, 1, meaning char_code_out valid.
REQ-014 SHALL have port char_ready_in, input, 1, meaning downstream renderer accepts the character.
REQ-015 SHALL have ports busy_out, row_done_out and row_abort_out, output, 1 each, meaning row in progress, row completed (1-cycle pulse) and row aborted (1-cycle pulse).

Function
REQ-016 SHALL accept a request only in IDLE with v_sync_in high and row_index_in < CPU_ELEMENTS; otherwise drop it silently with no output change.
REQ-017 SHALL read, for row r, the three words at addresses r, CPU_ELEMENTS+r and CPU_ELEMENTS+MEMORY_ELEMENTS+r, in that order.
REQ-018 SHALL emit per row exactly 14 characters: 4 hex chars of word 0, 0x20, 4 of word 1, 0x20, 4 of word 2; MSB nibble first.
REQ-019 SHALL map nibble 0-9 to 0x30-0x39 and A-F to 0x41-0x46.
REQ-020 SHALL use FSM states IDLE, FETCH (drive address), CAPTURE (latch aux_data_in), EMIT (4 nibbles), SEP (space), DONE.
REQ-021 SHALL, for a request accepted at edge k, assert busy_out and drive the first address from k+1, capture at k+2, and assert first char_valid_out from k+3.
REQ-022 SHALL transfer a character only on a cycle with char_valid_out and char_ready_in both high; char_code_out SHALL hold stable while valid and not ready.
REQ-023 SHALL, after the 14th transfer, go to DONE, pulse row_done_out for exactly one cycle, deassert busy_out, and return to IDLE on the next cycle.
REQ-024 SHALL, if v_sync_in is low on any cycle while busy, go to IDLE on the next edge, drop char_valid_out, pulse row_abort_out once, and not pulse row_done_out.
REQ-025 SHALL ignore row_request_in while busy, including in DONE.
REQ-026 SHALL hold aux_raddress_out at its last value outside FETCH.

Reset
REQ-027 SHALL, on reset_n_in low at any time including mid-row, immediately force IDLE, aux_raddress_out 0, char_code_out 0x00, and char_valid_out, busy_out, row_done_out and row_abort_out 0.
REQ-028 SHALL, after reset release, accept a request on the first qualifying edge.

Configuration
REQ-029 SHALL, with AUX_ROW_READER_ZERO_BLANK_EN defined, emit leading zero nibbles of each word as 0x20, always emitting the last nibble as a digit; the count stays 14.
REQ-030 SHALL, without AUX_ROW_READER_ZERO_BLANK_EN, emit all nibbles as hex digits.

Structure
REQ-031 SHALL place the FSM state enum, ASCII_SPACE (0x20), CHARS_PER_ROW (14) and the nibble-to-ASCII function in shared package aux_row_reader_pkg.
REQ-032 SHALL implement the 4-nibble shift/handshake logic in sub-module hex_word_serializer, instantiated once and reused for all three words.

Verification
REQ-033 SHALL cover the basic row: words 0x1234/0xABCD/0x00F0 at addresses 3/13/23, request row 3, ready held high -> "1234 ABCD 00F0", first valid at k+3, row_done_out pulses once.
REQ-034 SHALL cover backpressure: ready toggled 1-0-0-1 -> no character lost or duplicated, char_code_out stable during stalls.
REQ-035 SHALL cover invalid request: row_index_in 10, then a request while busy -> both dropped, no address change.
REQ-036 SHALL cover abort: v_sync_in driven low after the 6th character -> valid drops next cycle, row_abort_out pulses once, no row_done_out.
REQ-037 SHALL cover reset mid-EMIT: all outputs go to reset values asynchronously, then a request for row 0 completes normally.
REQ-038 SHALL cover the macro: word 0x00F0 with AUX_ROW_READER_ZERO_BLANK_EN defined -> "  F0"; 0x0000 -> "   0".
